// File: rtl/cl_code_table_gen_if.sv
// Control, status and query bundle for cl_code_table_gen: build start/lens in,
// busy/done/ready/error flags out, per-length count and (length, code) lookup.
interface cl_code_table_gen_if #(
    parameter int NSYM   = 16,
    parameter int LW     = 4,
    parameter int MAXLEN = 8,
    parameter int SYMW   = $clog2(NSYM),
    parameter int CW     = $clog2(NSYM + 1)
);
    logic                 start;
    logic [NSYM*LW-1:0]   lens;
    logic                 busy;
    logic                 done;
    logic                 ready;
    logic                 err_over;
    logic                 err_len;
    logic [LW-1:0]        cnt_len;
    logic [CW-1:0]        cnt_out;
    logic [LW-1:0]        lut_len;
    logic [MAXLEN-1:0]    lut_code;
    logic [SYMW-1:0]      lut_symb;
    logic                 lut_hit;

    modport master (
        output start, lens, cnt_len, lut_len, lut_code,
        input  busy, done, ready, err_over, err_len, cnt_out, lut_symb, lut_hit
    );

    modport slave (
        input  start, lens, cnt_len, lut_len, lut_code,
        output busy, done, ready, err_over, err_len, cnt_out, lut_symb, lut_hit
    );
endinterface

// File: rtl/cl_code_table_gen.sv
// Canonical-Huffman code table generator: scans one symbol per cycle per length
// (RFC1951 order), keeps per-length counts and serves a combinational lookup.
module cl_code_table_gen #(
    parameter int NSYM   = 16,
    parameter int LW     = 4,
    parameter int MAXLEN = 8,
    parameter int SYMW   = $clog2(NSYM),
    parameter int CW     = $clog2(NSYM + 1)
) (
    input  logic                clk,
    input  logic                rst,
    cl_code_table_gen_if.slave  bus
);
    localparam logic [LW-1:0]   MAXLEN_L = LW'(MAXLEN);
    localparam logic [LW-1:0]   LEN_ONE  = LW'(1);
    localparam logic [SYMW-1:0] LAST_POS = SYMW'(NSYM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE,
        S_READY
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       len_q, len_d;
    logic [SYMW-1:0]     pos_q, pos_d;
    logic [MAXLEN:0]     code_q, code_d;
    logic                err_over_q, err_over_d;
    logic                err_len_q, err_len_d;
    logic [CW-1:0]       cnt_q [2**LW];
    logic [CW-1:0]       cnt_d [2**LW];

    logic [LW-1:0]       lens_q [NSYM];
    logic [MAXLEN-1:0]   sym_code_q [NSYM];

    logic                cap_lens;
    logic                wr_code;
    logic                match;
    logic                ovf;
    logic [LW-1:0]       cur_len;
    logic [MAXLEN:0]     code_inc;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        pos_d      = pos_q;
        code_d     = code_q;
        err_over_d = err_over_q;
        err_len_d  = err_len_q;
        cnt_d      = cnt_q;
        cap_lens   = 1'b0;
        wr_code    = 1'b0;
        cur_len    = lens_q[pos_q];
        match      = (state_q == S_SCAN) && (cur_len == len_q);
        ovf        = match && ((code_q >> len_q) != '0);
        code_inc   = code_q + {{MAXLEN{1'b0}}, match};

        unique case (state_q)
            S_IDLE, S_READY: begin
                if (bus.start) begin
                    cap_lens   = 1'b1;
                    state_d    = S_SCAN;
                    len_d      = LEN_ONE;
                    pos_d      = '0;
                    code_d     = '0;
                    err_over_d = 1'b0;
                    err_len_d  = 1'b0;
                    for (int unsigned i = 0; i < 2**LW; i++) begin
                        cnt_d[i] = '0;
                    end
                end
            end
            S_SCAN: begin
                if (match) begin
                    wr_code       = 1'b1;
                    cnt_d[len_q]  = cnt_q[len_q] + 1'b1;
                end
                if (ovf) begin
                    err_over_d = 1'b1;
                end
                if ((len_q == LEN_ONE) && (cur_len > MAXLEN_L)) begin
                    err_len_d = 1'b1;
                end
                // After oversubscription the code stays put; passes continue only for counts and fixed latency.
                if (pos_q == LAST_POS) begin
                    pos_d = '0;
                    len_d = len_q + 1'b1;
                    if (!(err_over_q || ovf)) begin
                        code_d = {code_inc[MAXLEN-1:0], 1'b0};
                    end
                    if (len_q == MAXLEN_L) begin
                        state_d = S_DONE;
                    end
                end else begin
                    pos_d = pos_q + 1'b1;
                    if (!(err_over_q || ovf)) begin
                        code_d = code_inc;
                    end
                end
            end
            S_DONE: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            pos_q      <= '0;
            code_q     <= '0;
            err_over_q <= 1'b0;
            err_len_q  <= 1'b0;
            for (int unsigned i = 0; i < 2**LW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            pos_q      <= pos_d;
            code_q     <= code_d;
            err_over_q <= err_over_d;
            err_len_q  <= err_len_d;
            cnt_q      <= cnt_d;
        end
    end

    // Table storage carries no reset; lookups are gated by ready instead.
    always_ff @(posedge clk) begin
        if (cap_lens) begin
            for (int unsigned i = 0; i < NSYM; i++) begin
                lens_q[i] <= bus.lens[i*LW +: LW];
            end
        end
        if (wr_code) begin
            sym_code_q[pos_q] <= code_q[MAXLEN-1:0];
        end
    end

    logic [MAXLEN-1:0] lut_mask;
    logic              any_hit;
    logic              multi_hit;
    logic [SYMW-1:0]   hit_sym;
    logic              len_ok;
    logic              table_ready;

    always_comb begin
        lut_mask  = ~({MAXLEN{1'b1}} << bus.lut_len);
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        hit_sym   = '0;
        for (int unsigned i = 0; i < NSYM; i++) begin
            if ((lens_q[i] == bus.lut_len) &&
                (sym_code_q[i] == (bus.lut_code & lut_mask))) begin
                multi_hit = any_hit;
                any_hit   = 1'b1;
                hit_sym   = SYMW'(i);
            end
        end
    end

    assign table_ready  = (state_q == S_DONE) || (state_q == S_READY);
    assign len_ok       = (bus.lut_len != '0) && (bus.lut_len <= MAXLEN_L);

    assign bus.busy     = (state_q == S_SCAN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.ready    = table_ready;
    assign bus.err_over = err_over_q;
    assign bus.err_len  = err_len_q;
    assign bus.cnt_out  = cnt_q[bus.cnt_len];
    assign bus.lut_hit  = table_ready && len_ok && any_hit && !multi_hit;
    assign bus.lut_symb = bus.lut_hit ? hit_sym : '0;
endmodule
